// File: rtl/collision_pkg.sv
// collision_pkg: shared FSM states and sticky-vector indices for the collision detector
package collision_pkg;
  typedef enum logic [1:0] {ARMED, COOLDOWN, GAME_OVER} coll_state_t;
  localparam int COLL_SW  = 0;
  localparam int COLL_SB  = 1;
  localparam int COLL_SH  = 2;
  localparam int COLL_SG  = 3;
  localparam int COLL_GW  = 4;
  localparam int COLL_GGW = 5;
  localparam int COLL_N   = 6;
  localparam logic [COLL_N-1:0] SG_MASK = COLL_N'(1) << COLL_SG;
endpackage

// File: rtl/collision_detector_if.sv
// collision_detector_if: frame timing, per-pixel drawing requests and the collision/lives status returned to game logic
interface collision_detector_if;
  logic       startOfFrame;
  logic       restart;
  logic       smileyDrawingRequest;
  logic       boxDrawingRequest;
  logic       hartDrawingRequest;
  logic       wallDrawingRequest;
  logic       ghostDrawingRequest;
  logic       greenGhostDrawingRequest;
  logic       collSmileyWall;
  logic       collSmileyBox;
  logic       collSmileyHart;
  logic       collSmileyGhost;
  logic       collGhostWall;
  logic       collGreenGhostWall;
  logic [3:0] lives;
  logic       invulnerable;
  logic       gameOver;
  modport master (
    output startOfFrame, restart, smileyDrawingRequest, boxDrawingRequest, hartDrawingRequest,
           wallDrawingRequest, ghostDrawingRequest, greenGhostDrawingRequest,
    input  collSmileyWall, collSmileyBox, collSmileyHart, collSmileyGhost, collGhostWall,
           collGreenGhostWall, lives, invulnerable, gameOver
  );
  modport slave (
    input  startOfFrame, restart, smileyDrawingRequest, boxDrawingRequest, hartDrawingRequest,
           wallDrawingRequest, ghostDrawingRequest, greenGhostDrawingRequest,
    output collSmileyWall, collSmileyBox, collSmileyHart, collSmileyGhost, collGhostWall,
           collGreenGhostWall, lives, invulnerable, gameOver
  );
endinterface

// File: rtl/collision_detector_sticky_flags.sv
// frame_sticky_flags: per-frame overlap accumulator; at startOfFrame emits the closing frame's flags (masked by en) for one cycle
module frame_sticky_flags #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         sof,
  input  logic         clr,
  input  logic [N-1:0] set,
  input  logic [N-1:0] en,
  output logic [N-1:0] sticky,
  output logic [N-1:0] pulse
);
  logic [N-1:0] sticky_q, sticky_d, pulse_q, pulse_d;
  // overlap seen in the startOfFrame cycle seeds the new frame
  always_comb begin
    sticky_d = clr ? '0 : sof ? set : (sticky_q | set);
    pulse_d  = (sof && !clr) ? (sticky_q & en) : '0;
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      sticky_q <= '0;
      pulse_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      pulse_q  <= pulse_d;
    end
  assign sticky = sticky_q;
  assign pulse  = pulse_q;
endmodule

// File: rtl/collision_detector.sv
// collision_detector: turns per-pixel object overlaps into per-frame collision pulses and owns lives/invulnerability
module collision_detector
  import collision_pkg::*;
#(
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 60
) (
  input logic                 clk,
  input logic                 resetN,
  collision_detector_if.slave bus
);
  coll_state_t       state_q, state_d;
  logic [3:0]        lives_q, lives_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [COLL_N-1:0] set, en, sticky, pulse;
  logic              ghost_hit;
  assign set[COLL_SW]  = bus.smileyDrawingRequest & bus.wallDrawingRequest;
  assign set[COLL_SB]  = bus.smileyDrawingRequest & bus.boxDrawingRequest;
  assign set[COLL_SH]  = bus.smileyDrawingRequest & bus.hartDrawingRequest;
  assign set[COLL_SG]  = bus.smileyDrawingRequest & (bus.ghostDrawingRequest | bus.greenGhostDrawingRequest);
  assign set[COLL_GW]  = bus.ghostDrawingRequest & bus.wallDrawingRequest;
  assign set[COLL_GGW] = bus.greenGhostDrawingRequest & bus.wallDrawingRequest;
  assign ghost_hit = |(sticky & SG_MASK);
  assign en = (state_q == GAME_OVER) ? '0 : (state_q == COOLDOWN) ? ~SG_MASK : '1;
  frame_sticky_flags #(.N(COLL_N)) u_flags (
    .clk    (clk),
    .resetN (resetN),
    .sof    (bus.startOfFrame),
    .clr    (bus.restart),
    .set    (set),
    .en     (en),
    .sticky (sticky),
    .pulse  (pulse)
  );
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    if (bus.restart) begin
      state_d = ARMED;
      lives_d = 4'(LIVES_INIT);
      cnt_d   = '0;
    end else if (bus.startOfFrame)
      case (state_q)
        ARMED: if (ghost_hit) begin
          lives_d = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
          cnt_d   = 8'(INVULN_FRAMES);
          state_d = (lives_d == 4'd0) ? GAME_OVER : COOLDOWN;
        end
        COOLDOWN: begin
          cnt_d   = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
          state_d = (cnt_d == 8'd0) ? ARMED : COOLDOWN;
        end
        GAME_OVER: lives_d = 4'd0;
        default: state_d = ARMED;
      endcase
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= ARMED;
      lives_q <= 4'(LIVES_INIT);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
    end
  assign bus.collSmileyWall     = pulse[COLL_SW];
  assign bus.collSmileyBox      = pulse[COLL_SB];
  assign bus.collSmileyHart     = pulse[COLL_SH];
  assign bus.collSmileyGhost    = pulse[COLL_SG];
  assign bus.collGhostWall      = pulse[COLL_GW];
  assign bus.collGreenGhostWall = pulse[COLL_GGW];
  assign bus.lives              = lives_q;
  assign bus.invulnerable       = (state_q == COOLDOWN);
  assign bus.gameOver           = (state_q == GAME_OVER);
endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector: directed frame sequences with a queue of expected per-cycle outputs
module tb_collision_detector;
  localparam logic [5:0] SM = 6'b000001, BX = 6'b000010, HT = 6'b000100;
  localparam logic [5:0] WL = 6'b001000, GH = 6'b010000, GG = 6'b100000;
  localparam logic [5:0] C_SW = 6'd1, C_SB = 6'd2, C_SH = 6'd4, C_SG = 6'd8, C_GW = 6'd16, C_GGW = 6'd32;
  typedef struct {
    logic [5:0] coll;
    logic [3:0] lives;
    logic       inv;
    logic       go;
    string      tag;
  } exp_t;
  logic clk = 1'b0;
  logic resetN;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  collision_detector_if bus();
  collision_detector #(.LIVES_INIT(3), .INVULN_FRAMES(60)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic [5:0] r);
    {bus.greenGhostDrawingRequest, bus.ghostDrawingRequest, bus.wallDrawingRequest,
     bus.hartDrawingRequest, bus.boxDrawingRequest, bus.smileyDrawingRequest} = r;
  endtask
  task automatic expect_out(input logic [5:0] c, input logic [3:0] l, input logic i, input logic g, input string t);
    exp_t e;
    e.coll = c; e.lives = l; e.inv = i; e.go = g; e.tag = t;
    sb.push_back(e);
  endtask
  task automatic check();
    exp_t e;
    logic [5:0] c;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    c = {bus.collGreenGhostWall, bus.collGhostWall, bus.collSmileyGhost,
         bus.collSmileyHart, bus.collSmileyBox, bus.collSmileyWall};
    assert ({c, bus.lives, bus.invulnerable, bus.gameOver} === {e.coll, e.lives, e.inv, e.go}) else begin
      bad++;
      $error("FAIL %s: got coll=%b lives=%0d inv=%b go=%b, expected coll=%b lives=%0d inv=%b go=%b",
             e.tag, c, bus.lives, bus.invulnerable, bus.gameOver, e.coll, e.lives, e.inv, e.go);
    end
  endtask
  // one stimulus cycle with optional sof/restart; checks the following cycle and the one after it
  task automatic step(input logic [5:0] r, input logic s, input logic rs, input logic [5:0] ec,
                      input logic [3:0] el, input logic ei, input logic eg, input string t);
    drive(r);
    bus.startOfFrame = s;
    bus.restart = rs;
    expect_out(ec, el, ei, eg, t);
    expect_out(6'd0, el, ei, eg, {t, "_after"});
    @(negedge clk);
    drive(6'd0);
    bus.startOfFrame = 1'b0;
    bus.restart = 1'b0;
    check();
    @(negedge clk);
    check();
  endtask
  task automatic frame(input logic [5:0] r, input logic [5:0] ec, input logic [3:0] el,
                       input logic ei, input logic eg, input string t);
    drive(r);
    repeat (3) @(negedge clk);
    drive(6'd0);
    @(negedge clk);
    step(6'd0, 1'b1, 1'b0, ec, el, ei, eg, t);
  endtask
  initial begin
    resetN = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.restart = 1'b0;
    drive(6'd0);
    repeat (2) @(negedge clk);
    expect_out(6'd0, 4'd3, 1'b0, 1'b0, "reset");
    check();
    resetN = 1'b1;
    @(negedge clk);
    drive(SM | WL);
    repeat (5) @(negedge clk);
    drive(6'd0);
    step(6'd0, 1'b1, 1'b0, C_SW, 4'd3, 1'b0, 1'b0, "smiley_wall");
    frame(6'd0, 6'd0, 4'd3, 1'b0, 1'b0, "quiet_frame");
    frame(SM | BX | HT, C_SB | C_SH, 4'd3, 1'b0, 1'b0, "box_heart");
    frame(GH | GG | WL, C_GW | C_GGW, 4'd3, 1'b0, 1'b0, "ghosts_wall");
    frame(SM | GH, C_SG, 4'd2, 1'b1, 1'b0, "hit1");
    for (int i = 1; i <= 60; i++)
      frame(SM | GG | BX, C_SB, 4'd2, i < 60, 1'b0, "cooldown1");
    frame(SM | GH, C_SG, 4'd1, 1'b1, 1'b0, "hit2");
    for (int i = 1; i <= 60; i++)
      frame(6'd0, 6'd0, 4'd1, i < 60, 1'b0, "cooldown2");
    frame(SM | GH, C_SG, 4'd0, 1'b0, 1'b1, "hit3");
    frame(6'h3f, 6'd0, 4'd0, 1'b0, 1'b1, "game_over_all");
    step(6'd0, 1'b0, 1'b1, 6'd0, 4'd3, 1'b0, 1'b0, "restart_go");
    drive(SM | GH | WL);
    repeat (3) @(negedge clk);
    step(SM | GH | WL, 1'b1, 1'b1, 6'd0, 4'd3, 1'b0, 1'b0, "restart_sof");
    frame(6'd0, 6'd0, 4'd3, 1'b0, 1'b0, "after_restart");
    step(SM | WL, 1'b1, 1'b0, 6'd0, 4'd3, 1'b0, 1'b0, "sof_cycle_overlap");
    frame(6'd0, C_SW, 4'd3, 1'b0, 1'b0, "sof_overlap_next");
    frame(SM | GH, C_SG, 4'd2, 1'b1, 1'b0, "hit_pre_reset");
    drive(SM | GH | WL);
    repeat (3) @(negedge clk);
    resetN = 1'b0;
    drive(6'd0);
    @(negedge clk);
    expect_out(6'd0, 4'd3, 1'b0, 1'b0, "mid_reset");
    check();
    resetN = 1'b1;
    @(negedge clk);
    step(6'd0, 1'b1, 1'b0, 6'd0, 4'd3, 1'b0, 1'b0, "post_reset_sof");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
